ped_crossing_ctrl: RTL and testbench

Pedestrian signal controller that sits directly downstream of the traffic-light state machine and consumes its one-hot light output (green=3'b100, yellow=3'b010, red=3'b001). It latches pedestrian button requests, grants a WALK interval only at the start of a red phase, then gives a flashing DON'T-WALK clearance with a countdown. It drops WALK immediately on any red exit and locks out on an invalid light code.

---
 rtl/ped_crossing_ctrl.sv | 142 ++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK / DON'T-WALK controller driven by the
// one-hot light code of the upstream traffic-light FSM. Requests are latched,
// WALK is granted only at a red onset, and clearance flashes with a countdown.
// Any non-one-hot light code locks the block in FAULT until green is seen.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_in,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RED,
    WALK,
    FLASH,
    FAULT
  } state_t;

  state_t     state;
  logic [7:0] cycle_cnt;
  logic       walk_q;
  logic       prev_red;
  logic       is_red;
  logic       is_one_hot;
  logic       red_onset;

  assign is_red     = (light_in == 3'b001);
  assign is_one_hot = (light_in == 3'b100) || (light_in == 3'b010) || (light_in == 3'b001);
  assign red_onset  = is_red && !prev_red;

  // The lamp can never show WALK unless the light is red right now, even if
  // the register still holds WALK during the cycle the light leaves red.
  assign walk = walk_q & is_red;

  // Main controller: reset, then fault lockout, then red-exit abort, then the
  // normal request / grant / clearance sequence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      walk_q      <= 1'b0;
      dont_walk   <= 1'b1;
      countdown   <= 4'd0;
      req_pending <= 1'b0;
      fault       <= 1'b0;
      prev_red    <= 1'b1;
      cycle_cnt   <= 8'd0;
    end else begin
      prev_red <= is_red;
      if (!is_one_hot) begin
        state       <= FAULT;
        walk_q      <= 1'b0;
        dont_walk   <= 1'b1;
        countdown   <= 4'd0;
        req_pending <= 1'b0;
        fault       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dont_walk <= 1'b1;
            if (ped_btn) req_pending <= 1'b1;
            if (req_pending || ped_btn) state <= WAIT_RED;
          end
          WAIT_RED: begin
            dont_walk <= 1'b1;
            if (red_onset) begin
              state       <= WALK;
              cycle_cnt   <= WALK_LOAD;
              req_pending <= 1'b0;
              walk_q      <= 1'b1;
              dont_walk   <= 1'b0;
            end else if (ped_btn) begin
              req_pending <= 1'b1;
            end
          end
          WALK: begin
            if (!is_red) begin
              state     <= IDLE;
              walk_q    <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= 4'd0;
            end else if (cycle_cnt == 8'd0) begin
              state     <= FLASH;
              cycle_cnt <= {4'd0, FLASH_LOAD};
              countdown <= FLASH_LOAD;
              walk_q    <= 1'b0;
              dont_walk <= 1'b1;
            end else begin
              cycle_cnt <= cycle_cnt - 8'd1;
            end
          end
          FLASH: begin
            if (!is_red) begin
              state     <= IDLE;
              walk_q    <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= 4'd0;
            end else begin
              if (ped_btn) req_pending <= 1'b1;
              if (countdown == 4'd1) begin
                countdown <= 4'd0;
                dont_walk <= 1'b1;
                state     <= req_pending ? WAIT_RED : IDLE;
              end else begin
                countdown <= countdown - 4'd1;
                dont_walk <= ~dont_walk;
              end
            end
          end
          FAULT: begin
            walk_q      <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= 4'd0;
            req_pending <= 1'b0;
            if (light_in == 3'b100) begin
              state <= IDLE;
              fault <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            walk_q    <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed, table-driven bench for ped_crossing_ctrl
// with default parameters (WALK_CYCLES=8, FLASH_CYCLES=4), plus hand-written
// sequences for red abort, fault lockout and reset in WALK / during red.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light_in;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic [3:0] countdown;
  logic       req_pending;
  logic       fault;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  typedef struct {
    logic       rst_n;
    logic [2:0] light;
    logic       btn;
    logic       w;
    logic       dw;
    logic [3:0] cd;
    logic       rq;
    logic       f;
  } vec_t;

  vec_t vecs[$];

  ped_crossing_ctrl #(
    .WALK_CYCLES (8),
    .FLASH_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .light_in   (light_in),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .countdown  (countdown),
    .req_pending(req_pending),
    .fault      (fault)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge take them, then settle on the falling edge.
  task automatic applyStimulus(input logic rst_n, input logic [2:0] light, input logic btn);
    reset    = rst_n;
    light_in = light;
    ped_btn  = btn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic w, input logic dw, input logic [3:0] cd,
                          input logic rq, input logic f);
    checkOutput({tag, ".walk"}, {3'b0, walk}, {3'b0, w});
    checkOutput({tag, ".dont_walk"}, {3'b0, dont_walk}, {3'b0, dw});
    checkOutput({tag, ".countdown"}, countdown, cd);
    checkOutput({tag, ".req_pending"}, {3'b0, req_pending}, {3'b0, rq});
    checkOutput({tag, ".fault"}, {3'b0, fault}, {3'b0, f});
  endtask

  task automatic addVec(input logic rst_n, input logic [2:0] light, input logic btn, input logic w,
                        input logic dw, input logic [3:0] cd, input logic rq, input logic f);
    vec_t v;
    v.rst_n = rst_n; v.light = light; v.btn = btn;
    v.w = w; v.dw = dw; v.cd = cd; v.rq = rq; v.f = f;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset, then normal grant: button in green, 100->010->001, red held 14 cycles.
    addVec(0, G, 0, 0, 1, 0, 0, 0);
    addVec(0, G, 0, 0, 1, 0, 0, 0);
    addVec(1, G, 1, 0, 1, 0, 1, 0);
    addVec(1, G, 0, 0, 1, 0, 1, 0);
    addVec(1, Y, 0, 0, 1, 0, 1, 0);
    addVec(1, R, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) addVec(1, R, 0, 1, 0, 0, 0, 0);
    addVec(1, R, 0, 0, 1, 4, 0, 0);
    addVec(1, R, 0, 0, 0, 3, 0, 0);
    addVec(1, R, 0, 0, 1, 2, 0, 0);
    addVec(1, R, 0, 0, 0, 1, 0, 0);
    addVec(1, R, 0, 0, 1, 0, 0, 0);
    addVec(1, R, 0, 0, 1, 0, 0, 0);
    addVec(1, G, 0, 0, 1, 0, 0, 0);
    // Mid-red request: pressed on 3rd red cycle, served at the next red onset.
    addVec(1, Y, 0, 0, 1, 0, 0, 0);
    addVec(1, R, 0, 0, 1, 0, 0, 0);
    addVec(1, R, 0, 0, 1, 0, 0, 0);
    addVec(1, R, 1, 0, 1, 0, 1, 0);
    addVec(1, R, 0, 0, 1, 0, 1, 0);
    addVec(1, Y, 0, 0, 1, 0, 1, 0);
    addVec(1, R, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addVec(1, R, 0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].light, vecs[i].btn);
      checkAll($sformatf("vec%0d", i), vecs[i].w, vecs[i].dw, vecs[i].cd, vecs[i].rq, vecs[i].f);
    end

    // Red abort after 5 red cycles of WALK: lamp drops combinationally, then IDLE.
    light_in = G;
    #1;
    checkOutput("abort.walk_same_cycle", {3'b0, walk}, 4'd0);
    @(posedge clk);
    @(negedge clk);
    checkAll("abort", 0, 1, 0, 0, 0);

    // Fault during WALK, stays through red and yellow, clears after green.
    applyStimulus(1, G, 1);
    applyStimulus(1, Y, 0);
    applyStimulus(1, R, 0);
    checkAll("fault.pre_walk", 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b011, 0);
    checkAll("fault.enter", 0, 1, 0, 0, 1);
    applyStimulus(1, R, 1);
    checkAll("fault.red", 0, 1, 0, 0, 1);
    applyStimulus(1, Y, 0);
    checkAll("fault.yellow", 0, 1, 0, 0, 1);
    light_in = G;
    #1;
    checkOutput("fault.before_green_edge", {3'b0, fault}, 4'd1);
    @(posedge clk);
    @(negedge clk);
    checkAll("fault.exit", 0, 1, 0, 0, 0);

    // Reset asserted mid-WALK, released during red with the button held.
    applyStimulus(1, G, 1);
    applyStimulus(1, Y, 0);
    applyStimulus(1, R, 0);
    checkAll("rstwalk.walk", 1, 0, 0, 0, 0);
    applyStimulus(0, R, 1);
    checkAll("rstwalk.reset", 0, 1, 0, 0, 0);
    applyStimulus(1, R, 1);
    checkAll("rstred.release", 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, R, 0);
      checkAll($sformatf("rstred.hold%0d", i), 0, 1, 0, 1, 0);
    end
    applyStimulus(1, Y, 0);
    checkAll("rstred.yellow", 0, 1, 0, 1, 0);
    applyStimulus(1, R, 0);
    checkAll("rstred.grant", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
